// File: rtl/hex_expr_parser.sv
// Parses one "<hexA><op><hexB><term>" expression from a UART byte stream and
// hands the operands and opcode to the ALU stage with a single-cycle done pulse.
module hex_expr_parser #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [4*NUM_DIGITS-1:0]   op_a,
  output logic [4*NUM_DIGITS-1:0]   op_b,
  output logic [1:0]                opcode,
  output logic                      parser_done,
  output logic                      parse_err
);

  localparam int OPW = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {S_A, S_B, S_DONE, S_ERR} state_t;

  state_t          state, state_next;
  logic [OPW-1:0]  acc_a, acc_b;
  logic [CW-1:0]   cnt_a, cnt_b;
  logic [1:0]      opcode_acc;

  logic       is_hex, is_op, is_term, is_space, is_esc;
  logic [3:0] nib;
  logic [1:0] op_code;
  logic       shift_a, shift_b, clr_acc, latch_op, load_out, err_next;

  always_comb begin
    is_hex   = 1'b0;
    nib      = 4'h0;
    is_op    = 1'b1;
    op_code  = 2'b00;
    is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    is_space = (rx_data == 8'h20);
    is_esc   = (rx_data == 8'h1B);
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
    case (rx_data)
      8'h2B:   op_code = 2'b00;
      8'h2D:   op_code = 2'b01;
      8'h2A:   op_code = 2'b10;
      8'h2F:   op_code = 2'b11;
      default: is_op   = 1'b0;
    endcase
  end

  // S_DONE accepts bytes exactly like S_A; accumulators were emptied on entry.
  always_comb begin
    state_next = state;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    clr_acc    = 1'b0;
    latch_op   = 1'b0;
    load_out   = 1'b0;
    err_next   = 1'b0;
    if (state == S_DONE) state_next = S_A;
    if (rx_valid) begin
      if (is_esc) begin
        state_next = S_A;
        clr_acc    = 1'b1;
      end else if (!is_space) begin
        case (state)
          S_A, S_DONE: begin
            if (is_hex && cnt_a < MAX_CNT) begin
              shift_a = 1'b1;
            end else if (is_op && cnt_a != '0) begin
              latch_op   = 1'b1;
              state_next = S_B;
            end else begin
              state_next = S_ERR;
              err_next   = 1'b1;
              clr_acc    = 1'b1;
            end
          end
          S_B: begin
            if (is_hex && cnt_b < MAX_CNT) begin
              shift_b = 1'b1;
            end else if (is_term && cnt_b != '0) begin
              state_next = S_DONE;
              load_out   = 1'b1;
              clr_acc    = 1'b1;
            end else begin
              state_next = S_ERR;
              err_next   = 1'b1;
              clr_acc    = 1'b1;
            end
          end
          S_ERR: begin
            if (is_term) begin
              state_next = S_A;
              clr_acc    = 1'b1;
            end
          end
          default: state_next = S_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_A;
      acc_a      <= '0;
      acc_b      <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      opcode_acc <= 2'b00;
      op_a       <= '0;
      op_b       <= '0;
      opcode     <= 2'b00;
      parse_err  <= 1'b0;
    end else begin
      state     <= state_next;
      parse_err <= err_next;
      if (clr_acc) begin
        acc_a      <= '0;
        acc_b      <= '0;
        cnt_a      <= '0;
        cnt_b      <= '0;
        opcode_acc <= 2'b00;
      end else begin
        if (shift_a) begin
          acc_a <= {acc_a[OPW-5:0], nib};
          cnt_a <= cnt_a + CW'(1);
        end
        if (shift_b) begin
          acc_b <= {acc_b[OPW-5:0], nib};
          cnt_b <= cnt_b + CW'(1);
        end
        if (latch_op) opcode_acc <= op_code;
      end
      if (load_out) begin
        op_a   <= acc_a;
        op_b   <= acc_b;
        opcode <= opcode_acc;
      end
    end
  end

  assign parser_done = (state == S_DONE);

endmodule

// File: tb/tb_hex_expr_parser.sv
// Directed table-driven bench for hex_expr_parser plus hand-written sequences
// for reset, ESC abort, pulse timing and a byte arriving on the done cycle.
module tb_hex_expr_parser;

  logic        clk;
  logic        n_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] op_a, op_b;
  logic [1:0]  opcode;
  logic        parser_done, parse_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  hex_expr_parser #(.NUM_DIGITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .parser_done(parser_done), .parse_err(parse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       expr;
    int          exp_done;
    int          exp_err;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [1:0]  exp_op;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called 1 time unit after an edge; the byte is consumed by the next edge.
  task automatic apply_stimulus(input byte b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (parser_done) done_cnt++;
    if (parse_err)   err_cnt++;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    if (parser_done) done_cnt++;
    if (parse_err)   err_cnt++;
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) apply_stimulus(s[i]);
  endtask

  initial begin
    vecs[0]  = '{"1234/0010\015", 1, 0, 16'h1234, 16'h0010, 2'b11};
    vecs[1]  = '{"ab + CD=",      1, 0, 16'h00AB, 16'h00CD, 2'b00};
    vecs[2]  = '{"12345+1=",      0, 1, 16'h00AB, 16'h00CD, 2'b00};
    vecs[3]  = '{"F*2=",          1, 0, 16'h000F, 16'h0002, 2'b10};
    vecs[4]  = '{"+5=",           0, 1, 16'h000F, 16'h0002, 2'b10};
    vecs[5]  = '{"5+==",          0, 1, 16'h000F, 16'h0002, 2'b10};
    vecs[6]  = '{"1G=",           0, 1, 16'h000F, 16'h0002, 2'b10};
    vecs[7]  = '{"1+12345=",      0, 1, 16'h000F, 16'h0002, 2'b10};
    vecs[8]  = '{"FFFF-FFFF\015", 1, 0, 16'hFFFF, 16'hFFFF, 2'b01};
    vecs[9]  = '{"9a/B\015",      1, 0, 16'h009A, 16'h000B, 2'b11};
    vecs[10] = '{" 3\0332*1 =",   1, 0, 16'h0002, 16'h0001, 2'b10};
    vecs[11] = '{"==",            0, 1, 16'h0002, 16'h0001, 2'b10};
    vecs[12] = '{"A+5=",          1, 0, 16'h000A, 16'h0005, 2'b00};

    n_rst    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_op_a", 32'(op_a), 32'h0);
    check_output("reset_op_b", 32'(op_b), 32'h0);
    check_output("reset_opcode", 32'(opcode), 32'h0);
    check_output("reset_done", 32'(parser_done), 32'h0);
    check_output("reset_err", 32'(parse_err), 32'h0);
    n_rst = 1'b1;
    idle_cycle();

    foreach (vecs[v]) begin
      done_cnt = 0;
      err_cnt  = 0;
      send_string(vecs[v].expr);
      idle_cycle();
      idle_cycle();
      check_output($sformatf("v%0d_done_count", v), 32'(done_cnt), 32'(vecs[v].exp_done));
      check_output($sformatf("v%0d_err_count", v), 32'(err_cnt), 32'(vecs[v].exp_err));
      check_output($sformatf("v%0d_op_a", v), 32'(op_a), 32'(vecs[v].exp_a));
      check_output($sformatf("v%0d_op_b", v), 32'(op_b), 32'(vecs[v].exp_b));
      check_output($sformatf("v%0d_opcode", v), 32'(opcode), 32'(vecs[v].exp_op));
    end

    // parse_err lands on the cycle after the offending byte only
    apply_stimulus("+");
    check_output("err_pulse_at_plus", 32'(parse_err), 32'h1);
    apply_stimulus("5");
    check_output("err_clear_discard", 32'(parse_err), 32'h0);
    apply_stimulus("=");
    check_output("err_no_done", 32'(parser_done), 32'h0);

    // Reset in the middle of an expression
    send_string("12+3");
    n_rst = 1'b0;
    #1;
    check_output("midrst_op_a", 32'(op_a), 32'h0);
    check_output("midrst_op_b", 32'(op_b), 32'h0);
    check_output("midrst_opcode", 32'(opcode), 32'h0);
    check_output("midrst_done", 32'(parser_done), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    done_cnt = 0;
    err_cnt  = 0;
    send_string("1-1\015");
    check_output("sub_done_latency", 32'(parser_done), 32'h1);
    idle_cycle();
    check_output("sub_done_width", 32'(parser_done), 32'h0);
    check_output("sub_op_a", 32'(op_a), 32'h1);
    check_output("sub_op_b", 32'(op_b), 32'h1);
    check_output("sub_opcode", 32'(opcode), 32'h1);

    // ESC abort, then a byte delivered on the done cycle
    done_cnt = 0;
    err_cnt  = 0;
    send_string("12+");
    apply_stimulus(8'h1B);
    send_string("7/3=");
    check_output("esc_done", 32'(parser_done), 32'h1);
    check_output("esc_op_a", 32'(op_a), 32'h7);
    check_output("esc_op_b", 32'(op_b), 32'h3);
    check_output("esc_opcode", 32'(opcode), 32'h3);
    send_string("8+1=");
    idle_cycle();
    check_output("esc_err_count", 32'(err_cnt), 32'h0);
    check_output("donecyc_done_count", 32'(done_cnt), 32'h2);
    check_output("donecyc_op_a", 32'(op_a), 32'h8);
    check_output("donecyc_op_b", 32'(op_b), 32'h1);
    check_output("donecyc_opcode", 32'(opcode), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
